// File: rtl/serial_frame_encoder.sv
// Transmit path: buffers characters in a small FIFO, optionally XORs each with a key at pop,
// and shifts it out LSB-first as start/data/[even parity]/stop frames on a registered line.
module serial_frame_encoder #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          KEY_EN       = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [DATA_WIDTH-1:0]         key,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CycW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CycW-1:0]   CycLast   = CycW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]   BitLast   = BitW'(DATA_WIDTH - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CycW-1:0]       cyc_q, cyc_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]     count_q, count_d;
  logic                  in_ready_q, in_ready_d;

  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  push, pop, bit_end, fifo_empty;
  logic [DATA_WIDTH-1:0] head, word;

  assign push       = in_valid && in_ready_q;
  assign fifo_empty = (count_q == '0);
  assign bit_end    = (cyc_q == CycLast);
  assign head       = mem[rd_ptr_q];
  assign word       = KEY_EN ? (head ^ key) : head;

  assign in_ready   = in_ready_q;
  assign fifo_count = count_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Frame sequencing; the key is folded in only at pop so mid-frame key changes are ignored.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StStart;
          cyc_d   = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cyc_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d  = word;
      parity_d = ^word;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_d[0];
      StParity: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StStop) && (cyc_d == CycLast);
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    in_ready_d = (count_d != CountFull);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_serial_frame_encoder.sv
// Directed bench for serial_frame_encoder: a default instance (CLKS_PER_BIT=4, parity, key)
// and a fast instance (CLKS_PER_BIT=1, no parity, no key).
module tb_serial_frame_encoder;

  logic       clock;
  logic       reset_n;

  logic       in_valid_a, in_ready_a, serial_out_a, busy_a, frame_done_a;
  logic [7:0] in_data_a, key_a;
  logic [2:0] fifo_count_a;

  logic       in_valid_b, in_ready_b, serial_out_b, busy_b, frame_done_b;
  logic [7:0] in_data_b, key_b;
  logic [2:0] fifo_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] cap_fr [8];
  int          cap_wait, cap_unstable, cap_done_bad;
  int          rdy_bad, max_count, idle_bad;
  logic [7:0]  chars [6];
  logic [19:0] bits_b, dones_b;

  serial_frame_encoder #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .KEY_EN(1'b1)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .key(key_a), .serial_out(serial_out_a), .busy(busy_a),
    .frame_done(frame_done_a), .fifo_count(fifo_count_a)
  );

  serial_frame_encoder #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(1), .FIFO_DEPTH(4), .PARITY_EN(1'b0), .KEY_EN(1'b0)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .key(key_b), .serial_out(serial_out_b), .busy(busy_b),
    .frame_done(frame_done_b), .fifo_count(fifo_count_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame, bit i = i-th transmitted bit: start, data LSB first, even parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Call at a negedge; push one character into instance A (bounded wait on in_ready).
  task automatic push_a(input logic [7:0] d);
    int g;
    g = 0;
    in_valid_a = 1'b1;
    in_data_a  = d;
    while (!in_ready_a && g < 400) begin
      @(negedge clock);
      g++;
    end
    @(negedge clock);
    in_valid_a = 1'b0;
  endtask

  // Wait for a start bit on A, then record nf back-to-back frames of 11 bits x 4 cycles.
  task automatic capture_a(input int nf, input int timeout);
    cap_wait     = 0;
    cap_unstable = 0;
    cap_done_bad = 0;
    while (serial_out_a !== 1'b0 && cap_wait < timeout) begin
      @(negedge clock);
      cap_wait++;
    end
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < 11; b++) begin
        for (int c = 0; c < 4; c++) begin
          if (c == 0) cap_fr[f][b] = serial_out_a;
          else if (serial_out_a !== cap_fr[f][b]) cap_unstable++;
          if (frame_done_a !== ((b == 10) && (c == 3))) cap_done_bad++;
          @(negedge clock);
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00; key_a = 8'h00;
    in_valid_b = 1'b0; in_data_b = 8'h00; key_b = 8'h00;
    chars[0] = 8'h41; chars[1] = 8'h42; chars[2] = 8'h55;
    chars[3] = 8'hA3; chars[4] = 8'h00; chars[5] = 8'hFF;

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_serial", serial_out_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", frame_done_a, 0);
    check("rst_count", fifo_count_a, 0);
    check("rst_ready", in_ready_a, 1);
    check("rst_serial_b", serial_out_b, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Plaintext 0x41 (key 0), with latency and completion timing
    key_a = 8'h00;
    push_a(8'h41);
    check("t1_count_after_push", fifo_count_a, 1);
    check("t1_idle_on_accept", serial_out_a, 1);
    capture_a(1, 20);
    check("t1_latency", cap_wait, 1);
    check("t1_frame", cap_fr[0], 11'h482);
    check("t1_stable", cap_unstable, 0);
    check("t1_done_pos", cap_done_bad, 0);
    check("t1_busy_after", busy_a, 0);
    check("t1_line_after", serial_out_a, 1);

    // Encrypted 0x41 ^ 0x2B = 0x6A
    key_a = 8'h2B;
    push_a(8'h41);
    capture_a(1, 20);
    check("t2_frame", cap_fr[0], 11'h4D4);
    check("t2_done_pos", cap_done_bad, 0);
    repeat (2) @(negedge clock);

    // Six characters with in_valid held; FIFO fills, frames stay contiguous
    key_a     = 8'h00;
    rdy_bad   = 0;
    max_count = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int g;
          g = 0;
          in_valid_a = 1'b1;
          in_data_a  = chars[i];
          while (!in_ready_a && g < 400) begin
            @(negedge clock);
            g++;
          end
          @(negedge clock);
        end
        in_valid_a = 1'b0;
      end
      capture_a(6, 20);
      begin
        for (int n = 0; n < 6 * 44 + 4; n++) begin
          if (in_ready_a !== (fifo_count_a != 3'd4)) rdy_bad++;
          if (int'(fifo_count_a) > max_count) max_count = int'(fifo_count_a);
          @(negedge clock);
        end
      end
    join
    for (int f = 0; f < 6; f++) begin
      check($sformatf("t3_frame%0d", f), cap_fr[f], mk_frame(chars[f]));
    end
    check("t3_stable", cap_unstable, 0);
    check("t3_done_pos", cap_done_bad, 0);
    check("t3_ready_vs_full", rdy_bad, 0);
    check("t3_max_count", max_count, 4);
    repeat (4) @(negedge clock);
    check("t3_count_end", fifo_count_a, 0);
    check("t3_busy_end", busy_a, 0);

    // Key change mid-frame affects only the next frame
    key_a = 8'h2B;
    fork
      begin
        push_a(8'h41);
        push_a(8'h41);
        repeat (20) @(negedge clock);
        key_a = 8'h0F;
      end
      capture_a(2, 20);
    join
    check("t6_frame0_old_key", cap_fr[0], 11'h4D4);
    check("t6_frame1_new_key", cap_fr[1], 11'h49C);
    repeat (4) @(negedge clock);

    // Reset mid-DATA with two characters queued
    key_a = 8'h00;
    push_a(8'h55);
    push_a(8'h66);
    push_a(8'h77);
    repeat (8) @(negedge clock);
    check("t4_busy_pre", busy_a, 1);
    check("t4_count_pre", fifo_count_a, 2);
    reset_n = 1'b0;
    #1;
    check("t4_serial_async", serial_out_a, 1);
    check("t4_busy_async", busy_a, 0);
    check("t4_count_async", fifo_count_a, 0);
    check("t4_ready_async", in_ready_a, 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle_bad = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (serial_out_a !== 1'b1 || busy_a !== 1'b0 || fifo_count_a !== 3'd0 ||
          frame_done_a !== 1'b0) idle_bad++;
    end
    check("t4_silent_after_reset", idle_bad, 0);

    // One bit per cycle, no parity: 0xFF then 0x00
    @(negedge clock);
    in_valid_b = 1'b1;
    in_data_b  = 8'hFF;
    @(negedge clock);
    in_data_b  = 8'h00;
    check("t5_idle_on_accept", serial_out_b, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 0) in_valid_b = 1'b0;
      bits_b[i]  = serial_out_b;
      dones_b[i] = frame_done_b;
    end
    check("t5_bitstream", bits_b, 20'h803FE);
    check("t5_done_cycles", dones_b, 20'h80200);
    @(negedge clock);
    check("t5_busy_after", busy_b, 0);
    check("t5_count_after", fifo_count_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
